// File: rtl/gamepad_pkg.sv
// Shared constants for the gamepad command front-end: command codes, button
// indices, command FSM states and the press-to-command priority encoder.
`timescale 1ns/1ps
package gamepad_pkg;

   localparam logic [3:0] CMD_NONE        = 4'd0;
   localparam logic [3:0] CMD_UP          = 4'd1;
   localparam logic [3:0] CMD_DOWN        = 4'd2;
   localparam logic [3:0] CMD_LEFT        = 4'd3;
   localparam logic [3:0] CMD_RIGHT       = 4'd4;
   localparam logic [3:0] CMD_PLACE_LIXO  = 4'd5;
   localparam logic [3:0] CMD_PLACE_PRETA = 4'd6;
   localparam logic [3:0] CMD_REMOVE      = 4'd7;

   localparam int BTN_UP          = 0;
   localparam int BTN_DOWN        = 1;
   localparam int BTN_LEFT        = 2;
   localparam int BTN_RIGHT       = 3;
   localparam int BTN_PLACE_LIXO  = 4;
   localparam int BTN_PLACE_PRETA = 5;
   localparam int BTN_REMOVE      = 6;
   localparam int BTN_AUTO        = 10;
   localparam int BTN_MODE        = 11;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } cmdState_t;

   // Command code for button i is i+1; scanning downward lets the lowest index win.
   function automatic logic [3:0] pressToCmd(input logic [6:0] press);
      pressToCmd = CMD_NONE;
      for (int i = 6; i >= 0; i--) begin
         if (press[i]) pressToCmd = 4'(i + 1);
      end
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Synchronizes an asynchronous level and emits a registered one-cycle pulse
// on its rising edge, STAGES+1 cycles after the input rises.
`timescale 1ns/1ps
module edge_sync #(
   parameter int STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic asyncIn,
   output logic risePulse
);

   logic [STAGES-1:0] syncQ;
   logic              lastQ;

   always_ff @(posedge clock) begin
      if (reset) begin
         syncQ     <= '0;
         lastQ     <= 1'b0;
         risePulse <= 1'b0;
      end else begin
         syncQ[0] <= asyncIn;
         for (int i = 1; i < STAGES; i++) syncQ[i] <= syncQ[i-1];
         lastQ     <= syncQ[STAGES-1];
         risePulse <= syncQ[STAGES-1] & ~lastQ;
      end
   end

endmodule

// File: rtl/gamepad_cmd_ctrl.sv
// Per-frame gamepad sampler: turns new presses into handshaked map commands,
// owns the edit/auto mode flags and generates the robot step tick.
`timescale 1ns/1ps
module gamepad_cmd_ctrl
   import gamepad_pkg::*;
#(
   parameter int TICK_FRAMES = 30,
   parameter int SYNC_STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        v_sync,
   input  logic        manual_clock,
   input  logic [11:0] gamepad_input,
   input  logic        HabilitaNovaLeitura,
   output logic        cmd_valid,
   output logic [3:0]  cmd_code,
   output logic        flag_mode,
   output logic        auto_mode,
   output logic        clock_robo,
   output logic [7:0]  dropped_cmds,
   output logic        fsmState
);

   // Handshake: a command transfers on each clock edge where cmd_valid and
   // HabilitaNovaLeitura are both 1; cmd_code is frozen until that edge.

   logic       frameEvt, manualEvt;
   logic [6:0] prevCmd;
   logic       prevAuto, prevFlag;
   logic [6:0] cmdPress;
   logic [3:0] newCode;
   logic       newCmd, loadCmd, dropCmd;
   logic [7:0] frameCnt;
   logic       autoTick;
   logic       unusedBits;
   cmdState_t  state, stateNext;

   edge_sync #(.STAGES(SYNC_STAGES)) uFrameSync (
      .clock(clock), .reset(reset), .asyncIn(v_sync), .risePulse(frameEvt)
   );

   edge_sync #(.STAGES(SYNC_STAGES)) uManualSync (
      .clock(clock), .reset(reset), .asyncIn(manual_clock), .risePulse(manualEvt)
   );

   assign unusedBits = ^gamepad_input[9:7];
   assign cmdPress   = gamepad_input[6:0] & ~prevCmd;
   assign newCode    = frameEvt ? pressToCmd(cmdPress) : CMD_NONE;
   assign newCmd     = (newCode != CMD_NONE);

   always_comb begin
      stateNext = state;
      loadCmd   = 1'b0;
      dropCmd   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (newCmd) begin
               loadCmd   = 1'b1;
               stateNext = ST_PEND;
            end
         end
         ST_PEND: begin
            if (HabilitaNovaLeitura) begin
               if (newCmd) loadCmd   = 1'b1;
               else        stateNext = ST_IDLE;
            end else if (newCmd) begin
               dropCmd = 1'b1;
            end
         end
         default: stateNext = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state        <= ST_IDLE;
         cmd_code     <= CMD_NONE;
         dropped_cmds <= 8'd0;
         prevCmd      <= 7'd0;
         prevAuto     <= 1'b0;
         prevFlag     <= 1'b0;
         flag_mode    <= 1'b0;
         auto_mode    <= 1'b0;
         frameCnt     <= 8'd0;
         autoTick     <= 1'b0;
      end else begin
         state    <= stateNext;
         autoTick <= 1'b0;
         if (loadCmd) cmd_code <= newCode;
         if (dropCmd && dropped_cmds != 8'hFF) dropped_cmds <= dropped_cmds + 8'd1;
         if (frameEvt) begin
            prevCmd  <= gamepad_input[6:0];
            prevAuto <= gamepad_input[BTN_AUTO];
            prevFlag <= gamepad_input[BTN_MODE];
            if (gamepad_input[BTN_AUTO] && !prevAuto) auto_mode <= ~auto_mode;
            if (gamepad_input[BTN_MODE] && !prevFlag) flag_mode <= ~flag_mode;
         end
         // Counter sits at 0 in manual mode, so entering auto starts a fresh period.
         if (!auto_mode) begin
            frameCnt <= 8'd0;
         end else if (frameEvt) begin
            if (frameCnt == 8'(TICK_FRAMES - 1)) begin
               frameCnt <= 8'd0;
               autoTick <= 1'b1;
            end else begin
               frameCnt <= frameCnt + 8'd1;
            end
         end
      end
   end

   assign cmd_valid  = (state == ST_PEND);
   assign fsmState   = (state == ST_PEND);
   assign clock_robo = autoTick | (~auto_mode & manualEvt);

endmodule

// File: tb/tb_gamepad_cmd_ctrl.sv
// Directed bench for gamepad_cmd_ctrl: press edge detection, priority, drops,
// handshake, mode toggles, auto/manual step tick and mid-operation reset.
`timescale 1ns/1ps
module tb_gamepad_cmd_ctrl;

   localparam int TICKS = 3;
   localparam int SYNCS = 2;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        v_sync = 1'b0;
   logic        manual_clock = 1'b0;
   logic [11:0] gamepad_input = 12'h000;
   logic        HabilitaNovaLeitura = 1'b0;
   logic        cmd_valid;
   logic [3:0]  cmd_code;
   logic        flag_mode;
   logic        auto_mode;
   logic        clock_robo;
   logic [7:0]  dropped_cmds;
   logic        fsmState;

   int checks = 0;
   int failures = 0;
   logic [3:0] expQ[$];
   logic [3:0] gotQ[$];
   int   roboPulses = 0;
   int   roboWide = 0;
   logic roboLast = 1'b0;
   int   base;

   gamepad_cmd_ctrl #(.TICK_FRAMES(TICKS), .SYNC_STAGES(SYNCS)) dut (
      .clock(clock),
      .reset(reset),
      .v_sync(v_sync),
      .manual_clock(manual_clock),
      .gamepad_input(gamepad_input),
      .HabilitaNovaLeitura(HabilitaNovaLeitura),
      .cmd_valid(cmd_valid),
      .cmd_code(cmd_code),
      .flag_mode(flag_mode),
      .auto_mode(auto_mode),
      .clock_robo(clock_robo),
      .dropped_cmds(dropped_cmds),
      .fsmState(fsmState)
   );

   // clock / reset
   always #5 clock = ~clock;

   // transfer and step-tick monitor
   always @(posedge clock) begin
      if (!reset && cmd_valid && HabilitaNovaLeitura) gotQ.push_back(cmd_code);
      if (clock_robo) roboPulses++;
      if (clock_robo && roboLast) roboWide++;
      roboLast = clock_robo;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic checkXfers(input string tag);
      checkVal({tag, " count"}, gotQ.size(), expQ.size());
      for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
         checkVal({tag, " code"}, gotQ[i], expQ[i]);
      gotQ.delete();
      expQ.delete();
   endtask

   // one full frame: buttons stable, v_sync high 6 cycles then low 4
   task automatic frame(input logic [11:0] btns);
      gamepad_input = btns;
      v_sync = 1'b1;
      tick(6);
      v_sync = 1'b0;
      tick(4);
   endtask

   task automatic manualPulse();
      manual_clock = 1'b1;
      tick(6);
      manual_clock = 1'b0;
      tick(4);
   endtask

   initial begin
      tick(3);
      checkVal("reset cmd_valid", cmd_valid, 0);
      checkVal("reset cmd_code", cmd_code, 0);
      checkVal("reset flag_mode", flag_mode, 0);
      checkVal("reset auto_mode", auto_mode, 0);
      checkVal("reset clock_robo", clock_robo, 0);
      checkVal("reset dropped", dropped_cmds, 0);
      checkVal("reset fsmState", fsmState, 0);
      reset = 1'b0;
      tick(2);

      // held UP over 5 frames -> one transfer of code 1
      HabilitaNovaLeitura = 1'b1;
      for (int i = 0; i < 5; i++) frame(12'h001);
      frame(12'h000);
      expQ.push_back(4'd1);
      checkXfers("held up");

      // LEFT and PLACE_PRETA together -> LEFT only, no drop
      frame(12'h024);
      frame(12'h000);
      expQ.push_back(4'd3);
      checkXfers("priority");
      checkVal("priority dropped", dropped_cmds, 0);

      // ready low: RIGHT pends, REMOVE is dropped, then RIGHT transfers
      HabilitaNovaLeitura = 1'b0;
      gamepad_input = 12'h008;
      v_sync = 1'b1;
      tick(3);
      checkVal("event cycle valid", cmd_valid, 0);
      tick(1);
      checkVal("valid latency", cmd_valid, 1);
      tick(2);
      v_sync = 1'b0;
      tick(4);
      checkVal("pend code", cmd_code, 4);
      frame(12'h048);
      checkVal("drop code held", cmd_code, 4);
      checkVal("drop count", dropped_cmds, 1);
      checkVal("drop still valid", cmd_valid, 1);
      expQ.push_back(4'd4);
      HabilitaNovaLeitura = 1'b1;
      tick(2);
      checkVal("accept valid low", cmd_valid, 0);
      frame(12'h000);
      checkXfers("drop");

      // auto mode with TICKS=3
      base = roboPulses;
      frame(12'h400);
      checkVal("auto on", auto_mode, 1);
      frame(12'h000);
      frame(12'h000);
      checkVal("auto 2 frames", roboPulses - base, 0);
      frame(12'h000);
      checkVal("auto 3 frames", roboPulses - base, 1);
      manualPulse();
      checkVal("auto ignores manual", roboPulses - base, 1);
      for (int i = 0; i < 3; i++) frame(12'h000);
      checkVal("auto 6 frames", roboPulses - base, 2);
      frame(12'h400);
      frame(12'h000);
      checkVal("auto off", auto_mode, 0);
      checkVal("auto exit pulses", roboPulses - base, 2);

      // manual mode: latency then 4 pulses total
      base = roboPulses;
      manual_clock = 1'b1;
      tick(SYNCS + 1);
      checkVal("manual latency", clock_robo, 1);
      tick(1);
      checkVal("manual width", clock_robo, 0);
      tick(2);
      manual_clock = 1'b0;
      tick(4);
      for (int i = 0; i < 3; i++) manualPulse();
      checkVal("manual pulses", roboPulses - base, 4);

      // flag_mode toggles
      frame(12'h800);
      frame(12'h000);
      checkVal("flag on", flag_mode, 1);
      frame(12'h800);
      frame(12'h000);
      checkVal("flag off", flag_mode, 0);

      // reset while DOWN pending with flag set
      HabilitaNovaLeitura = 1'b0;
      frame(12'h802);
      checkVal("pre-reset valid", cmd_valid, 1);
      checkVal("pre-reset flag", flag_mode, 1);
      reset = 1'b1;
      tick(1);
      checkVal("mid reset cmd_valid", cmd_valid, 0);
      checkVal("mid reset cmd_code", cmd_code, 0);
      checkVal("mid reset flag_mode", flag_mode, 0);
      checkVal("mid reset auto_mode", auto_mode, 0);
      checkVal("mid reset clock_robo", clock_robo, 0);
      checkVal("mid reset dropped", dropped_cmds, 0);
      reset = 1'b0;
      HabilitaNovaLeitura = 1'b1;
      tick(6);
      checkXfers("after reset");

      checkVal("robo width", roboWide, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
